// File: rtl/cone_stim_deser.sv
// cone_stim_deser
//   Feeds a combinational cone under test (CUT) from a 1-bit serial link.
//   Serial bits are collected into a VEC_W-bit vector and launched onto the CUT
//   inputs in one step. The CUT output is sampled RESP_LAT cycles later and
//   returned over a valid/ready response port.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   clear     in   1      synchronous abort of a partial vector / pending response
//   s_valid   in   1      serial stimulus bit valid
//   s_ready   out  1      block accepts a stimulus bit (high in SHIFT)
//   s_data    in   1      serial stimulus bit, first accepted bit -> vec_out[0]
//   vec_out   out  VEC_W  vector driving CUT inputs (bit i -> n_i)
//   resp_in   in   1      CUT output
//   r_valid   out  1      captured response valid
//   r_ready   in   1      response consumer ready
//   r_data    out  1      captured response bit
//   resp_cnt  out  CNT_W  responses handed off, wraps
//
// state  | meaning
// -------+------------------------------------------------------------
// SHIFT  | collecting serial bits into shreg, s_ready high
// APPLY  | vector launched, counting down until the CUT output settles
// RESP   | response captured, holding r_valid/r_data until handoff

module cone_stim_deser #(
    parameter int VEC_W    = 39,
    parameter int RESP_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    output logic [VEC_W-1:0] vec_out,
    input  logic             resp_in,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_data,
    output logic [CNT_W-1:0] resp_cnt
);

    localparam int BCNT_W = $clog2(VEC_W);
    localparam int WCNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(VEC_W - 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(RESP_LAT - 1);

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        APPLY = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [BCNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [VEC_W-1:0]    shreg, shreg_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic [VEC_W-1:0]    vec_nxt;
    logic                r_valid_nxt;
    logic                r_data_nxt;
    logic [CNT_W-1:0]    resp_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            shreg    <= '0;
            wcnt     <= '0;
            vec_out  <= '0;
            r_valid  <= 1'b0;
            r_data   <= 1'b0;
            resp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            wcnt     <= wcnt_nxt;
            vec_out  <= vec_nxt;
            r_valid  <= r_valid_nxt;
            r_data   <= r_data_nxt;
            resp_cnt <= resp_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        wcnt_nxt     = wcnt;
        vec_nxt      = vec_out;
        r_valid_nxt  = r_valid;
        r_data_nxt   = r_data;
        resp_cnt_nxt = resp_cnt;
        s_ready      = (state == SHIFT);

        if (clear) begin
            // vec_out, r_data and resp_cnt keep their values across an abort
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
            shreg_nxt   = '0;
            r_valid_nxt = 1'b0;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (s_valid) begin
                        shreg_nxt[bit_cnt] = s_data;
                        if (bit_cnt == LAST_BIT) begin
                            // last bit bypasses shreg so the vector launches on this edge
                            vec_nxt     = {s_data, shreg[VEC_W-2:0]};
                            bit_cnt_nxt = '0;
                            wcnt_nxt    = WAIT_INIT;
                            state_nxt   = APPLY;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BCNT_W'(1);
                        end
                    end
                end
                APPLY: begin
                    if (wcnt == '0) begin
                        r_data_nxt  = resp_in;
                        r_valid_nxt = 1'b1;
                        state_nxt   = RESP;
                    end else begin
                        wcnt_nxt = wcnt - WCNT_W'(1);
                    end
                end
                RESP: begin
                    if (r_ready) begin
                        r_valid_nxt  = 1'b0;
                        resp_cnt_nxt = resp_cnt + CNT_W'(1);
                        state_nxt    = SHIFT;
                    end
                end
                default: begin
                    state_nxt = SHIFT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cone_stim_deser.sv
module tb_cone_stim_deser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance 0: VEC_W=39, RESP_LAT=1, CNT_W=16; CUT modelled as n_122 = n_0
    logic        clear1, s_valid1, s_data1, r_ready1;
    logic        s_ready1, r_valid1, r_data1, resp_in1;
    logic [38:0] vec_out1;
    logic [15:0] resp_cnt1;

    // instance 1: VEC_W=4, RESP_LAT=3, CNT_W=4; CUT output toggles every cycle
    logic        clear2, s_valid2, s_data2, r_ready2;
    logic        s_ready2, r_valid2, r_data2;
    logic        resp_in2 = 1'b0;
    logic [3:0]  vec_out2;
    logic [3:0]  resp_cnt2;

    assign resp_in1 = vec_out1[0];
    always @(negedge clk) resp_in2 <= ~resp_in2;

    cone_stim_deser #(.VEC_W(39), .RESP_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .vec_out(vec_out1), .resp_in(resp_in1),
        .r_valid(r_valid1), .r_ready(r_ready1), .r_data(r_data1),
        .resp_cnt(resp_cnt1)
    );

    cone_stim_deser #(.VEC_W(4), .RESP_LAT(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .vec_out(vec_out2), .resp_in(resp_in2),
        .r_valid(r_valid2), .r_ready(r_ready2), .r_data(r_data2),
        .resp_cnt(resp_cnt2)
    );

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: collecting bits, 1: waiting for the CUT, 2: holding a response
    logic [38:0] m_bits[2];
    logic [38:0] m_vec[2];
    int          m_n[2];
    int          m_ph[2];
    int          m_wait[2];
    logic        m_rv[2];
    logic        m_rd[2];
    int          m_cnt[2];

    task automatic step(input int k, input logic clr, input logic sv, input logic sd,
                        input logic rr, input logic rin);
        int vw, lat, md;
        vw  = (k == 0) ? 39 : 4;
        lat = (k == 0) ? 1 : 3;
        md  = (k == 0) ? 65536 : 16;
        if (clr) begin
            m_n[k] = 0; m_ph[k] = 0; m_rv[k] = 1'b0;
        end else if (m_ph[k] == 0) begin
            if (sv) begin
                m_bits[k][m_n[k]] = sd;
                m_n[k]++;
                if (m_n[k] == vw) begin
                    m_vec[k]  = m_bits[k];
                    m_n[k]    = 0;
                    m_wait[k] = lat;
                    m_ph[k]   = 1;
                end
            end
        end else if (m_ph[k] == 1) begin
            m_wait[k]--;
            if (m_wait[k] == 0) begin
                m_rd[k] = rin; m_rv[k] = 1'b1; m_ph[k] = 2;
            end
        end else if (rr) begin
            m_rv[k]  = 1'b0;
            m_cnt[k] = (m_cnt[k] + 1) % md;
            m_ph[k]  = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_bits[k] = '0; m_vec[k] = '0; m_n[k] = 0; m_ph[k] = 0;
                m_wait[k] = 0; m_rv[k] = 1'b0; m_rd[k] = 1'b0; m_cnt[k] = 0;
            end
        end else begin
            step(0, clear1, s_valid1, s_data1, r_ready1, m_vec[0][0]);
            step(1, clear2, s_valid2, s_data2, r_ready2, resp_in2);
        end
    end

    // cycle-by-cycle compare against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("s_ready1",  s_ready1,  m_ph[0] == 0);
                chk("vec_out1",  vec_out1,  m_vec[0]);
                chk("r_valid1",  r_valid1,  m_rv[0]);
                chk("r_data1",   r_data1,   m_rd[0]);
                chk("resp_cnt1", resp_cnt1, m_cnt[0]);
                chk("s_ready2",  s_ready2,  m_ph[1] == 0);
                chk("vec_out2",  vec_out2,  m_vec[1]);
                chk("r_valid2",  r_valid2,  m_rv[1]);
                chk("r_data2",   r_data2,   m_rd[1]);
                chk("resp_cnt2", resp_cnt2, m_cnt[1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // valid/ready serial sender, first bit is v[0]
    task automatic send(input int k, input logic [38:0] v, input int nb);
        int  i, guard;
        logic rdy;
        i = 0; guard = 0;
        while (i < nb && guard < 400) begin
            if (k == 0) begin s_valid1 = 1'b1; s_data1 = v[i]; rdy = s_ready1; end
            else        begin s_valid2 = 1'b1; s_data2 = v[i]; rdy = s_ready2; end
            tick();
            if (rdy) i++;
            guard++;
        end
        if (k == 0) s_valid1 = 1'b0; else s_valid2 = 1'b0;
        chk("send_bits", i, nb);
    endtask

    logic [38:0] vp, vq, va, vb, vc, vd;
    logic        cap;

    initial begin
        vp = 39'h5555555555;
        vq = 39'h2AAAAAAAAA;
        va = 39'h123456789A;
        vb = 39'h7F0F0F0F01;
        vc = 39'h00FFFFFFFF;
        vd = 39'h5A5A5A5A5B;
        rst_n = 1'b0;
        {clear1, s_valid1, s_data1, r_ready1} = '0;
        {clear2, s_valid2, s_data2, r_ready2} = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_s_ready", s_ready1, 1'b1);
        chk("rst_vec", vec_out1, 39'h0);
        chk("rst_rvalid", r_valid1, 1'b0);
        tick();

        // alternating pattern, consumer always ready
        r_ready1 = 1'b1;
        send(0, vp, 39);
        chk("p_vec", vec_out1, 39'h5555555555);
        chk("p_rvalid_low", r_valid1, 1'b0);
        tick();
        chk("p_rvalid", r_valid1, 1'b1);
        chk("p_rdata", r_data1, 1'b1);
        tick();
        chk("p_cnt", resp_cnt1, 16'd1);
        chk("p_sready", s_ready1, 1'b1);

        // consumer stalls for 10 cycles, serial bits offered meanwhile
        r_ready1 = 1'b0;
        send(0, vq, 39);
        tick();
        for (int c = 0; c < 10; c++) begin
            s_valid1 = 1'b1; s_data1 = 1'($urandom);
            tick();
            chk("stall_rvalid", r_valid1, 1'b1);
            chk("stall_rdata", r_data1, 1'b0);
            chk("stall_sready", s_ready1, 1'b0);
        end
        s_valid1 = 1'b0;
        chk("stall_cnt", resp_cnt1, 16'd1);
        r_ready1 = 1'b1;
        tick();
        chk("stall_release_cnt", resp_cnt1, 16'd2);
        chk("stall_vec", vec_out1, 39'h2AAAAAAAAA);

        // back-to-back vectors, vec_out held at A while B shifts
        send(0, va, 39);
        send(0, vb, 20);
        chk("b2b_hold", vec_out1, 39'h123456789A);
        send(0, vb >> 20, 19);
        chk("b2b_new", vec_out1, 39'h7F0F0F0F01);
        repeat (2) tick();
        chk("b2b_cnt", resp_cnt1, 16'd4);

        // abort after 20 bits
        send(0, vc, 20);
        clear1 = 1'b1;
        tick();
        clear1 = 1'b0;
        chk("clr_keep_vec", vec_out1, 39'h7F0F0F0F01);
        chk("clr_sready", s_ready1, 1'b1);
        send(0, vd, 39);
        chk("clr_clean_vec", vec_out1, 39'h5A5A5A5A5B);
        repeat (2) tick();
        chk("clr_cnt", resp_cnt1, 16'd5);

        // clear coinciding with a handoff discards the handoff
        r_ready1 = 1'b0;
        send(0, va, 39);
        tick();
        chk("clrhs_rvalid", r_valid1, 1'b1);
        clear1 = 1'b1; r_ready1 = 1'b1;
        tick();
        clear1 = 1'b0; r_ready1 = 1'b0;
        chk("clrhs_rvalid_low", r_valid1, 1'b0);
        chk("clrhs_cnt", resp_cnt1, 16'd5);
        chk("clrhs_rdata", r_data1, 1'b0);

        // RESP_LAT=3 instance: counter wrap after 16 handoffs
        r_ready2 = 1'b1;
        for (int n = 0; n < 16; n++) send(1, 39'((n * 5 + 3) & 15), 4);
        repeat (6) tick();
        chk("wrap_cnt0", resp_cnt2, 4'd0);
        send(1, 39'hA, 4);
        chk("lat_vec", vec_out2, 4'hA);
        tick();
        tick();
        @(negedge clk); #1;
        cap = resp_in2;
        tick();
        chk("lat_rvalid", r_valid2, 1'b1);
        chk("lat_sample", r_data2, cap);
        tick();
        chk("wrap_cnt1", resp_cnt2, 4'd1);

        // reset in the middle of a vector
        send(0, vb, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", vec_out1, 39'h0);
        chk("mid_rst_cnt", resp_cnt1, 16'd0);
        chk("mid_rst_sready", s_ready1, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
